// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared definitions for the fetch/data memory-port arbiter:
//               FSM state encodings, port-owner encodings, default widths
//               and a helper that turns an owner code into a port mask.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int WIDTH_DEFAULT   = 16;
    localparam int LATENCY_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_DONE   = 3'd2,
        ST_DUMP   = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    // Owner codes; mask bit 0 is the fetch port, bit 1 the data port.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    function automatic logic [1:0] owner_mask(input logic owner);
        return (owner == OWN_DM) ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational grant picker for the memory-port arbiter.
//               Masks out ineligible ports, then chooses between the fetch
//               and data requesters.
//               Optional macro MEM_ARB_RR_EN: round-robin tie-break using
//               last_grant; otherwise fixed data-over-fetch priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       if_req_i,
    input  logic       dm_req_i,
    input  logic [1:0] inelig_i,
    input  logic       last_grant_i,
    output logic       grant_valid_o,
    output logic       grant_owner_o
);

    logic w_if_elig;
    logic w_dm_elig;

    assign w_if_elig = if_req_i & ~inelig_i[0];
    assign w_dm_elig = dm_req_i & ~inelig_i[1];

`ifdef MEM_ARB_RR_EN
    // Tie goes to the port that was not granted most recently; a lone
    // requester wins regardless of history.
    always_comb begin
        grant_valid_o = w_if_elig | w_dm_elig;
        if (w_if_elig && w_dm_elig) begin
            grant_owner_o = (last_grant_i == OWN_IF) ? OWN_DM : OWN_IF;
        end else begin
            grant_owner_o = w_dm_elig ? OWN_DM : OWN_IF;
        end
    end
`else
    // History is irrelevant with fixed priority.
    logic w_unused_last_grant;
    assign w_unused_last_grant = last_grant_i;

    // Fixed priority: the data stage always beats the fetch stage.
    always_comb begin
        grant_valid_o = w_if_elig | w_dm_elig;
        grant_owner_o = w_dm_elig ? OWN_DM : OWN_IF;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Sequences a single-port data memory between the fetch stage
//               and the memory stage. One request is latched at a time, the
//               memory controls are held for LATENCY cycles, read data is
//               registered per port and a one-cycle done pulse is returned.
//               On halt the in-flight access drains, one createdump pulse is
//               issued and the arbiter parks until reset.
//               Optional macro MEM_ARB_RR_EN: round-robin tie-break between
//               the two ports (adds a last_grant register).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int LATENCY = LATENCY_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_done,
    input  logic             dm_req,
    input  logic             dm_wr,
    input  logic [WIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0] dm_wdata,
    output logic [WIDTH-1:0] dm_rdata,
    output logic             dm_done,
    input  logic             halt,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_enable,
    output logic             mem_wr,
    output logic             mem_createdump,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             halted
);

    localparam int            CW       = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    state_e           state_q;
    logic             owner_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0] mem_wdata_q;
    logic             mem_enable_q;
    logic             mem_wr_q;
    logic             mem_createdump_q;
    logic [WIDTH-1:0] if_rdata_q;
    logic [WIDTH-1:0] dm_rdata_q;
    logic             if_done_q;
    logic             dm_done_q;
    logic             halted_q;

    logic [1:0]       w_inelig;
    logic             w_last_grant;
    logic             w_grant_valid;
    logic             w_grant_owner;

    // The port being completed in DONE may still hold req for the same
    // operation; keep it out of this cycle's arbitration.
    assign w_inelig = (state_q == ST_DONE) ? owner_mask(owner_q) : 2'b00;

`ifdef MEM_ARB_RR_EN
    logic last_grant_q;
    assign w_last_grant = last_grant_q;

    // Remember the most recent grant for the round-robin tie-break.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= OWN_IF;
        end else if ((state_q == ST_IDLE || state_q == ST_DONE) && !halt && w_grant_valid) begin
            last_grant_q <= w_grant_owner;
        end
    end
`else
    assign w_last_grant = OWN_IF;
`endif

    mem_arb_pick u_pick (
        .if_req_i      (if_req),
        .dm_req_i      (dm_req),
        .inelig_i      (w_inelig),
        .last_grant_i  (w_last_grant),
        .grant_valid_o (w_grant_valid),
        .grant_owner_o (w_grant_owner)
    );

    // Arbiter FSM; every output is registered and computed alongside the
    // state transition so it is valid in the cycle the new state begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            owner_q          <= OWN_IF;
            cnt_q            <= '0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            mem_enable_q     <= 1'b0;
            mem_wr_q         <= 1'b0;
            mem_createdump_q <= 1'b0;
            if_rdata_q       <= '0;
            dm_rdata_q       <= '0;
            if_done_q        <= 1'b0;
            dm_done_q        <= 1'b0;
            halted_q         <= 1'b0;
        end else begin
            if_done_q        <= 1'b0;
            dm_done_q        <= 1'b0;
            mem_createdump_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (halt) begin
                        // Nothing is in flight here, so halt wins outright.
                        state_q          <= ST_DUMP;
                        mem_createdump_q <= 1'b1;
                    end else if (w_grant_valid) begin
                        state_q      <= ST_ACCESS;
                        owner_q      <= w_grant_owner;
                        cnt_q        <= CNT_INIT;
                        mem_enable_q <= 1'b1;
                        if (w_grant_owner == OWN_DM) begin
                            mem_addr_q  <= dm_addr;
                            mem_wdata_q <= dm_wdata;
                            mem_wr_q    <= dm_wr;
                        end else begin
                            // Fetch is always a read.
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                            mem_wr_q    <= 1'b0;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        if (!mem_wr_q) begin
                            if (owner_q == OWN_DM) begin
                                dm_rdata_q <= mem_rdata;
                            end else begin
                                if_rdata_q <= mem_rdata;
                            end
                        end
                        if (owner_q == OWN_DM) begin
                            dm_done_q <= 1'b1;
                        end else begin
                            if_done_q <= 1'b1;
                        end
                        state_q      <= ST_DONE;
                        mem_enable_q <= 1'b0;
                        mem_wr_q     <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_wdata_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DUMP: begin
                    state_q  <= ST_HALTED;
                    halted_q <= 1'b1;
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_enable     = mem_enable_q;
    assign mem_wr         = mem_wr_q;
    assign mem_createdump = mem_createdump_q;
    assign if_rdata       = if_rdata_q;
    assign dm_rdata       = dm_rdata_q;
    assign if_done        = if_done_q;
    assign dm_done        = dm_done_q;
    assign halted         = halted_q;

endmodule
`default_nettype wire
